sync_fifo: RTL and testbench

Single-clock synchronous FIFO buffering 8-bit data words between a producer and a consumer in the same clock domain. It provides registered read data, full/empty status, an occupancy count, and one-cycle overflow/underflow error pulses. It is a generic leaf block: no flow control beyond the status flags, and no clock-domain crossing.

---
 rtl/sync_fifo_pkg.sv | 23 ++
 rtl/sync_fifo_mem.sv | 53 +++++
 rtl/sync_fifo.sv | 121 ++++++++++++
 tb/tb_sync_fifo.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_pkg
//  Description : Shared defaults and width helpers for the single-clock FIFO.
//                Contents:
//                  c_DEFAULT_DATA_W - default data word width (8)
//                  c_DEFAULT_DEPTH  - default number of entries (8)
//                  cnt_width()      - occupancy counter width, $clog2(depth)+1
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    localparam int c_DEFAULT_DATA_W = 8;
    localparam int c_DEFAULT_DEPTH  = 8;

    // The occupancy counter must represent 0..depth inclusive, so it needs
    // one more bit than a pointer into the array.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_mem
//  Description : DEPTH x DATA_W register array with one write port and one
//                registered read port. The array itself is not reset; only
//                the read data register clears on reset.
//  Ports       : clk      - rising-edge clock
//                rst      - synchronous active-high reset (read register)
//                i_we     - write enable
//                i_waddr  - write address
//                i_wdata  - write data
//                i_re     - read enable; loads o_rdata when high
//                i_raddr  - read address
//                o_rdata  - registered read data, holds when i_re is low
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage is deliberately left out of reset so it maps onto plain flops
    // or distributed RAM without a reset network.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock synchronous FIFO with registered read data,
//                full/empty flags, occupancy count and one-cycle
//                overflow/underflow error pulses.
//  Ports       : clk        - rising-edge clock
//                rst        - synchronous active-high reset
//                wen        - write request
//                ren        - read request
//                buf_in     - write data, sampled with wen
//                buf_out    - registered read data
//                full       - count == DEPTH
//                empty      - count == 0
//                fifo_count - occupancy, 0..DEPTH
//                overflow   - pulse: write was rejected at previous edge
//                underflow  - pulse: read was rejected at previous edge
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = c_DEFAULT_DATA_W,
    parameter int DEPTH  = c_DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wen,
    input  logic                   ren,
    input  logic [DATA_W-1:0]      buf_in,
    output logic [DATA_W-1:0]      buf_out,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam int                 c_CNT_W    = cnt_width(DEPTH);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_acc;
    logic               w_rd_acc;

    // Flags decode from the registered count, so acceptance below always
    // uses the pre-edge status. When full, a simultaneous read does not
    // free a slot for the write in the same cycle.
    assign w_full   = (r_count == c_FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wen && !w_full;
    assign w_rd_acc = ren && !w_empty;

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap at DEPTH
    // without any explicit compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wen && w_full;
            r_underflow <= ren && w_empty;
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (buf_in),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (buf_out)
    );

    assign full       = w_full;
    assign empty      = w_empty;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo
//  Description : Directed self-checking bench for sync_fifo (DATA_W=8,
//                DEPTH=8). Inputs change on the falling edge; outputs are
//                sampled on the following falling edge, after the DUT edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    logic       clk;
    logic       rst;
    logic       wen;
    logic       ren;
    logic [7:0] buf_in;
    logic [7:0] buf_out;
    logic       full;
    logic       empty;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       underflow;

    int errors = 0;
    int checks = 0;

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wen        (wen),
        .ren        (ren),
        .buf_in     (buf_in),
        .buf_out    (buf_out),
        .full       (full),
        .empty      (empty),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int cnt, input int f,
                          input int e, input int ov, input int ud);
        chk({tag, ".count"},     32'(fifo_count), cnt);
        chk({tag, ".full"},      32'(full),       f);
        chk({tag, ".empty"},     32'(empty),      e);
        chk({tag, ".overflow"},  32'(overflow),   ov);
        chk({tag, ".underflow"}, 32'(underflow),  ud);
    endtask

    task automatic chk_out(input string tag, input int d);
        chk({tag, ".buf_out"}, 32'(buf_out), d);
    endtask

    // Apply one cycle of stimulus and return at the next falling edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wen    = w;
        ren    = r;
        buf_in = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        wen    = 1'b0;
        ren    = 1'b0;
        buf_in = 8'h00;
        step(0, 0, 8'h00);
        rst = 1'b0;
        step(0, 0, 8'h00);
        chk_st("reset_idle", 0, 0, 1, 0, 0);
        chk_out("reset_idle", 0);

        // Fill past capacity: writes 9..12 are rejected.
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 8'(i));
            if (i <= 8) chk_st($sformatf("fill%0d", i), i, (i == 8) ? 1 : 0, 0, 0, 0);
            else        chk_st($sformatf("fill%0d", i), 8, 1, 0, 1, 0);
        end
        step(0, 0, 8'h00);
        chk_st("fill_idle", 8, 1, 0, 0, 0);

        // Drain: data 1..8, then one rejected read.
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 8'h00);
            chk_out($sformatf("drain%0d", i), i);
            chk_st($sformatf("drain%0d", i), 8 - i, 0, (i == 8) ? 1 : 0, 0, 0);
        end
        step(0, 1, 8'h00);
        chk_out("drain_extra", 8);
        chk_st("drain_extra", 0, 0, 1, 0, 1);
        step(0, 0, 8'h00);
        chk_st("drain_idle", 0, 0, 1, 0, 0);

        // Simultaneous read/write from empty: first cycle is write-only.
        for (int k = 1; k <= 12; k++) begin
            step(1, 1, 8'(k));
            if (k == 1) begin
                chk_out("rw1", 8);
                chk_st("rw1", 1, 0, 0, 0, 1);
            end else begin
                chk_out($sformatf("rw%0d", k), k - 1);
                chk_st($sformatf("rw%0d", k), 1, 0, 0, 0, 0);
            end
        end
        step(0, 1, 8'h00);
        chk_out("rw_drain", 12);
        chk_st("rw_drain", 0, 0, 1, 0, 0);

        // Full with simultaneous read/write: read wins, write rejected.
        for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h20 + i));
        chk_st("fill2", 8, 1, 0, 0, 0);
        step(1, 1, 8'hFF);
        chk_out("full_rw", 8'h20);
        chk_st("full_rw", 7, 0, 0, 1, 0);
        for (int i = 1; i < 8; i++) begin
            step(0, 1, 8'h00);
            chk_out($sformatf("full_rw_drain%0d", i), 8'h20 + i);
        end
        chk_st("full_rw_drained", 0, 0, 1, 0, 0);

        // Pointer wrap: 5 in/out, then 8 in/out.
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i));
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 8'h00);
            chk_out($sformatf("wrap5_%0d", i), 8'h40 + i);
        end
        for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h50 + i));
        chk_st("wrap8_full", 8, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 8'h00);
            chk_out($sformatf("wrap8_%0d", i), 8'h50 + i);
        end
        chk_st("wrap8_empty", 0, 0, 1, 0, 0);

        // Reset mid-stream; reset outranks the concurrent write.
        for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h60 + i));
        step(0, 1, 8'h00);
        chk_out("pre_rst", 8'h60);
        rst = 1'b1;
        step(1, 1, 8'h99);
        rst = 1'b0;
        chk_st("mid_rst", 0, 0, 1, 0, 0);
        chk_out("mid_rst", 0);
        step(1, 0, 8'h70);
        chk_st("post_rst_wr", 1, 0, 0, 0, 0);
        step(0, 1, 8'h00);
        chk_out("post_rst_rd", 8'h70);
        chk_st("post_rst_rd", 0, 0, 1, 0, 0);
        step(0, 1, 8'h00);
        chk_out("post_rst_under", 8'h70);
        chk_st("post_rst_under", 0, 0, 1, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sync_fifo
`default_nettype wire
